// File: rtl/spk_acc_pkg.sv
// Shared types and helpers for the spike-weight accumulator: FSM states,
// lane geometry and the saturating lane addition.
package spk_acc_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_OUT   = 2'd2
  } state_e;

  localparam int LANES   = 4;
  localparam int W_WIDTH = 8;

  // Adds a signed weight to a sign-extended accumulator and clamps the result
  // to the signed range of a width-bit register (width <= 32).
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0]        acc,
    input logic signed [W_WIDTH-1:0] w,
    input int                        width
  );
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(acc) + 33'(w);
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (width - 1));
    if (sum > hi) begin
      return hi[31:0];
    end else if (sum < lo) begin
      return lo[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/sat_acc_lane.sv
// One membrane accumulator lane: sign-extends an 8-bit weight, adds it with
// saturation when enabled, and clears on request (clear wins over add).
module sat_acc_lane
  import spk_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        add_en_i,
  input  logic                        clr_i,
  input  logic signed [W_WIDTH-1:0]   w_i,
  output logic signed [ACC_WIDTH-1:0] acc_o
);

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_en_i) begin
      acc_d = ACC_WIDTH'(sat_add(32'(acc_q), w_i, ACC_WIDTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/spk_wght_accum.sv
// Spike-driven weight accumulator: each accepted spike reads one packed weight
// word and adds its four signed bytes into four saturating membrane lanes.
module spk_wght_accum
  import spk_acc_pkg::*;
#(
  parameter int BIT_WIDTH      = 31,
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int ACC_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        spk_valid,
  output logic                        spk_ready,
  input  logic [RAM_ADDR_WIDTH-1:0]   spk_idx,
  input  logic                        ts_end,
  output logic                        ren,
  output logic [RAM_ADDR_WIDTH-1:0]   raddr,
  input  logic [BIT_WIDTH:0]          rdat,
  output logic                        acc_valid,
  input  logic                        acc_ready,
  output logic [LANES*ACC_WIDTH-1:0]  acc_out
);

  state_e state_q, state_d;
  logic   rd_pend_q, rd_pend_d;
  logic   acc_clr;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (ts_end) state_d = S_FLUSH;
      S_FLUSH: state_d = S_OUT;
      S_OUT:   if (acc_ready) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  assign spk_ready = (state_q == S_RUN);
  assign acc_valid = (state_q == S_OUT);
  assign ren       = spk_valid & spk_ready;
  assign raddr     = spk_idx;
  assign acc_clr   = acc_valid & acc_ready;
  // The read word lands one cycle after ren; rd_pend marks that cycle.
  assign rd_pend_d = ren;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sat_acc_lane #(
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .add_en_i (rd_pend_q),
      .clr_i    (acc_clr),
      .w_i      (rdat[W_WIDTH*i +: W_WIDTH]),
      .acc_o    (acc_out[ACC_WIDTH*i +: ACC_WIDTH])
    );
  end

endmodule

// File: tb/tb_spk_wght_accum.sv
// Bench for spk_wght_accum: registered weight RAM model plus an integer
// per-lane reference that sums accepted spike weights with clamping.
module tb_spk_wght_accum;

  localparam int AW    = 5;
  localparam int ACC_W = 16;
  localparam int LIM_HI = (1 <<< (ACC_W - 1)) - 1;
  localparam int LIM_LO = -(1 <<< (ACC_W - 1));

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             spk_valid = 1'b0;
  logic             spk_ready;
  logic [AW-1:0]    spk_idx = '0;
  logic             ts_end = 1'b0;
  logic             ren;
  logic [AW-1:0]    raddr;
  logic [31:0]      rdat = '0;
  logic             acc_valid;
  logic             acc_ready = 1'b0;
  logic [4*ACC_W-1:0] acc_out;

  logic [31:0] mem [32];
  int          m [4];
  int          errors = 0;
  int          checks = 0;

  spk_wght_accum #(
    .BIT_WIDTH(31), .RAM_DEPTH(32), .RAM_ADDR_WIDTH(AW), .ACC_WIDTH(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .spk_valid(spk_valid), .spk_ready(spk_ready),
    .spk_idx(spk_idx), .ts_end(ts_end), .ren(ren), .raddr(raddr), .rdat(rdat),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ren) rdat <= mem[raddr];
  end

  function automatic int lane_of(input logic [4*ACC_W-1:0] v, input int i);
    logic signed [ACC_W-1:0] s;
    s = v[ACC_W*i +: ACC_W];
    return int'(s);
  endfunction

  task automatic model_add(input logic [31:0] w);
    logic signed [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      m[i] = m[i] + int'(b);
      if (m[i] > LIM_HI) m[i] = LIM_HI;
      if (m[i] < LIM_LO) m[i] = LIM_LO;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m[i] = 0;
  endtask

  task automatic spike(input int idx, input bit te);
    spk_valid = 1'b1;
    spk_idx   = AW'(idx);
    ts_end    = te;
    if (spk_ready) model_add(mem[idx]);
    @(negedge clk);
    spk_valid = 1'b0;
    ts_end    = 1'b0;
  endtask

  // Enter at the negedge after the ts_end cycle (FLUSH); leave in S_OUT.
  task automatic wait_out(input string name);
    int n;
    checks++;
    if (acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s flush_valid got=%b exp=0", name, acc_valid);
    end
    @(negedge clk);
    checks++;
    if (acc_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s out_latency got=%b exp=1", name, acc_valid);
      n = 0;
      while (acc_valid !== 1'b1 && n < 5) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lane_of(acc_out, i) !== m[i]) begin
        errors++;
        $display("FAIL %s lane%0d got=%0d exp=%0d", name, i, lane_of(acc_out, i), m[i]);
      end
    end
  endtask

  task automatic handshake(input string name);
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    model_clear();
    checks++;
    if (acc_valid !== 1'b0 || spk_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_hs got=v%b r%b exp=v0 r1", name, acc_valid, spk_ready);
    end
  endtask

  task automatic close_ts(input string name);
    ts_end = 1'b1;
    @(negedge clk);
    ts_end = 1'b0;
    wait_out(name);
    handshake(name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ren !== 1'b0 || spk_ready !== 1'b1 || acc_valid !== 1'b0 || acc_out !== '0) begin
      errors++;
      $display("FAIL reset outs got=ren%b rdy%b v%b out%h exp=ren0 rdy1 v0 out0",
               ren, spk_ready, acc_valid, acc_out);
    end
    spk_valid = 1'b1;
    #1;
    checks++;
    if (ren !== 1'b1) begin
      errors++;
      $display("FAIL reset ren_follow got=%b exp=1", ren);
    end
    spk_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    mem[3] = 32'h01020304;
    spike(3, 1'b0);
    ts_end = 1'b1;
    @(negedge clk);
    ts_end = 1'b0;
    wait_out("basic");
    checks++;
    if (lane_of(acc_out, 3) !== 1 || lane_of(acc_out, 0) !== 4) begin
      errors++;
      $display("FAIL basic order got=l3:%0d l0:%0d exp=l3:1 l0:4",
               lane_of(acc_out, 3), lane_of(acc_out, 0));
    end
    handshake("basic");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_FFFF;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (spk_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b ready k=%0d got=%b exp=1", k, spk_ready);
      end
      spike($urandom_range(31), 1'b0);
    end
    close_ts("b2b");
  endtask

  task automatic test_saturation();
    mem[7] = 32'h7F7F_7F7F;
    for (int k = 0; k < 300; k++) spike(7, 1'b0);
    close_ts("sat_pos");
    mem[9] = 32'h8080_8080;
    for (int k = 0; k < 300; k++) spike(9, 1'b0);
    close_ts("sat_neg");
  endtask

  task automatic test_same_cycle();
    mem[1] = 32'h0000_0005;
    spike(1, 1'b1);
    wait_out("same_cyc");
    handshake("same_cyc");
    close_ts("next_zero");
  endtask

  task automatic test_hold();
    logic [4*ACC_W-1:0] snap;
    mem[2] = 32'h11F3_7A02;
    mem[4] = 32'hC0DE_2201;
    spike(2, 1'b0);
    spike(4, 1'b1);
    wait_out("hold");
    snap = acc_out;
    spk_valid = 1'b1;
    spk_idx   = AW'(2);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (spk_ready !== 1'b0 || ren !== 1'b0 || acc_valid !== 1'b1 || acc_out !== snap) begin
        errors++;
        $display("FAIL hold k=%0d got=rdy%b ren%b v%b out%h exp=rdy0 ren0 v1 out%h",
                 k, spk_ready, ren, acc_valid, acc_out, snap);
      end
      @(negedge clk);
    end
    handshake("hold");
    spike(2, 1'b0);
    close_ts("hold_next");
  endtask

  task automatic test_rst_mid();
    mem[5] = 32'h0403_0201;
    spike(5, 1'b0);
    spike(5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    checks++;
    if (acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid valid got=%b exp=0", acc_valid);
    end
    close_ts("rst_mid");
  endtask

  task automatic test_random();
    int n;
    bit te;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      n = $urandom_range(20, 1);
      te = 1'b0;
      for (int k = 0; k < n; k++) begin
        te = (k == n - 1) && ($urandom_range(1) == 1);
        spike($urandom_range(31), te);
        if ($urandom_range(3) == 0 && !te) @(negedge clk);
      end
      if (te) begin
        wait_out("random");
        handshake("random");
      end else begin
        close_ts("random");
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    model_clear();
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_same_cycle();
    test_hold();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
